// File: rtl/cksum_sched_pkg.sv
// Shared bus widths, scheduler state codes and the job-table entry type.
// Widths are fixed at 32 bits for both address and length buses.
`ifndef CKSUM_SCHED_DEF_V
`define CKSUM_SCHED_DEF_V
`define TRUE        1'b1
`define FALSE       1'b0
`define ADDR_BUS    31:0
`define DATA_BUS    31:0
`define ZERO_WORD   32'h0000_0000
`define JOB_IDX_BUS 2:0
`define SCHED_IDLE  3'd0
`define SCHED_SCAN  3'd1
`define SCHED_ISSUE 3'd2
`define SCHED_WAIT  3'd3
`define SCHED_REL   3'd4
`define SCHED_FIN   3'd5
`endif

package cksum_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = `SCHED_IDLE,
    ST_SCAN  = `SCHED_SCAN,
    ST_ISSUE = `SCHED_ISSUE,
    ST_WAIT  = `SCHED_WAIT,
    ST_REL   = `SCHED_REL,
    ST_FIN   = `SCHED_FIN
  } sched_st_t;

  typedef struct packed {
    logic             en;
    logic [`ADDR_BUS] field_off;
    logic [`DATA_BUS] field_len;
    logic [`ADDR_BUS] dst_off;
  } job_t;

  // An entry is issued only when enabled and it covers at least one byte.
  function automatic logic job_live(input job_t j);
    return j.en && (j.field_len != `ZERO_WORD);
  endfunction

  // The engine works on 16-bit words, so every offset and length must be even.
  function automatic logic cfg_even(input logic [`ADDR_BUS] off,
                                    input logic [`DATA_BUS] len,
                                    input logic [`ADDR_BUS] dst);
    return !(off[0] | len[0] | dst[0]);
  endfunction

endpackage

// File: rtl/cksum_sched_job_pick.sv
// Combinational priority pick: lowest live entry at or above the cursor.
// Zero latency; no flow control.
module cksum_job_pick #(
  parameter int NUM_JOBS = 4
) (
  input  logic [NUM_JOBS-1:0]         i_live,
  input  logic [$clog2(NUM_JOBS)-1:0] i_cursor,
  output logic                        o_found,
  output logic [$clog2(NUM_JOBS)-1:0] o_idx
);
  localparam int IDX_W = $clog2(NUM_JOBS);

  // Walking downward lets the lowest qualifying index win the last assignment.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NUM_JOBS - 1; k >= 0; k--) begin
      if (i_live[k] && (IDX_W'(k) >= i_cursor)) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/cksum_sched.sv
// Checksum job sequencer: walks the enabled table entries per packet, one engine handshake each.
// Start at accept+2, 3 cycles overhead per job; packets accepted only in IDLE (pkt_ready_o).
module cksum_sched
  import cksum_sched_pkg::*;
#(
  parameter int NUM_JOBS       = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we_i,
  input  logic [$clog2(NUM_JOBS)-1:0] cfg_idx_i,
  input  logic                        cfg_en_i,
  input  logic [`ADDR_BUS]            cfg_field_off_i,
  input  logic [`DATA_BUS]            cfg_field_len_i,
  input  logic [`ADDR_BUS]            cfg_dst_off_i,
  output logic                        cfg_err_o,
  input  logic                        pkt_valid_i,
  input  logic [`ADDR_BUS]            pkt_base_i,
  output logic                        pkt_ready_o,
  output logic                        cksum_start_o,
  output logic [`ADDR_BUS]            cksum_field_start_o,
  output logic [`DATA_BUS]            cksum_field_len_o,
  output logic [`ADDR_BUS]            cksum_dst_field_start_o,
  input  logic                        cksum_ready_i,
  output logic                        done_o,
  output logic                        timeout_o
);
  localparam int                IDX_W    = $clog2(NUM_JOBS);
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_JOBS - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  job_t             r_cfg [NUM_JOBS];
  job_t             r_act [NUM_JOBS];
  sched_st_t        r_state;
  logic [IDX_W-1:0] r_cursor;
  logic [`ADDR_BUS] r_base;
  logic [WD_W-1:0]  r_wd;
  logic             r_abort;
  logic             r_cfg_err;
  logic             r_pkt_ready;
  logic             r_start;
  logic [`ADDR_BUS] r_field_start;
  logic [`DATA_BUS] r_field_len;
  logic [`ADDR_BUS] r_dst_start;
  logic             r_done;
  logic             r_timeout;

  logic [NUM_JOBS-1:0] w_live;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick;
  logic                w_cfg_ok;

  always_comb begin
    w_live = '0;
    for (int k = 0; k < NUM_JOBS; k++) begin
      w_live[k] = job_live(r_act[k]);
    end
  end

  cksum_job_pick #(
    .NUM_JOBS (NUM_JOBS)
  ) u_pick (
    .i_live   (w_live),
    .i_cursor (r_cursor),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  assign w_cfg_ok = (r_state == ST_IDLE) &&
                    cfg_even(cfg_field_off_i, cfg_field_len_i, cfg_dst_off_i);

  // Live configuration table; the running packet works from its own snapshot in r_act.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= `FALSE;
      for (int k = 0; k < NUM_JOBS; k++) begin
        r_cfg[k] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we_i && !w_cfg_ok;
      if (cfg_we_i && w_cfg_ok) begin
        r_cfg[cfg_idx_i] <= '{en:        cfg_en_i,
                              field_off: cfg_field_off_i,
                              field_len: cfg_field_len_i,
                              dst_off:   cfg_dst_off_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cursor      <= '0;
      r_base        <= `ZERO_WORD;
      r_wd          <= '0;
      r_abort       <= `FALSE;
      r_pkt_ready   <= `TRUE;
      r_start       <= `FALSE;
      r_field_start <= `ZERO_WORD;
      r_field_len   <= `ZERO_WORD;
      r_dst_start   <= `ZERO_WORD;
      r_done        <= `FALSE;
      r_timeout     <= `FALSE;
      for (int k = 0; k < NUM_JOBS; k++) begin
        r_act[k] <= '0;
      end
    end else begin
      r_done    <= `FALSE;
      r_timeout <= `FALSE;
      case (r_state)
        ST_IDLE: begin
          if (pkt_valid_i) begin
            // Snapshot taken from the pre-write table, so a same-cycle cfg write waits for the next packet.
            for (int k = 0; k < NUM_JOBS; k++) begin
              r_act[k] <= r_cfg[k];
            end
            r_base      <= pkt_base_i;
            r_cursor    <= '0;
            r_pkt_ready <= `FALSE;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_found) begin
            r_field_start <= r_base + r_act[w_pick].field_off;
            r_field_len   <= r_act[w_pick].field_len;
            r_dst_start   <= r_base + r_act[w_pick].dst_off;
            r_start       <= `TRUE;
            r_wd          <= '0;
            r_cursor      <= w_pick;
            r_state       <= ST_ISSUE;
          end else begin
            r_done  <= `TRUE;
            r_state <= ST_FIN;
          end
        end
        ST_ISSUE: begin
          // A high ready here is left over from the previous job; only a low ready is an ack.
          if (r_wd == WD_LAST) begin
            r_start   <= `FALSE;
            r_done    <= `TRUE;
            r_timeout <= `TRUE;
            r_abort   <= `TRUE;
            r_state   <= ST_REL;
          end else begin
            r_wd <= r_wd + WD_W'(1);
            if (!cksum_ready_i) begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cksum_ready_i) begin
            r_start <= `FALSE;
            r_state <= ST_REL;
          end else if (r_wd == WD_LAST) begin
            r_start   <= `FALSE;
            r_done    <= `TRUE;
            r_timeout <= `TRUE;
            r_abort   <= `TRUE;
            r_state   <= ST_REL;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_REL: begin
          if (r_abort) begin
            r_abort     <= `FALSE;
            r_pkt_ready <= `TRUE;
            r_state     <= ST_IDLE;
          end else if (r_cursor == LAST_IDX) begin
            r_done  <= `TRUE;
            r_state <= ST_FIN;
          end else begin
            r_cursor <= r_cursor + IDX_W'(1);
            r_state  <= ST_SCAN;
          end
        end
        ST_FIN: begin
          r_pkt_ready <= `TRUE;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_pkt_ready <= `TRUE;
          r_start     <= `FALSE;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_err_o               = r_cfg_err;
  assign pkt_ready_o             = r_pkt_ready;
  assign cksum_start_o           = r_start;
  assign cksum_field_start_o     = r_field_start;
  assign cksum_field_len_o       = r_field_len;
  assign cksum_dst_field_start_o = r_dst_start;
  assign done_o                  = r_done;
  assign timeout_o               = r_timeout;

endmodule
